// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: queues SPI commands, launches one byte transfer at a time and returns each received byte as a response
module spi_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_slave,
  input  logic [7:0] req_data,
  output logic       start,
  output logic [1:0] slaveSelect,
  output logic [7:0] masterDataToSend,
  input  logic [7:0] masterDataReceived,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_slave,
  output logic       rsp_err,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_CAPTURE, S_GAP} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_mem_slave [DEPTH];
  logic [7:0]    r_mem_data  [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_cnt;
  logic [1:0]    r_slave;
  logic [7:0]    r_data;
  logic          r_rsp_valid, r_rsp_err;
  logic [1:0]    r_rsp_slave;
  logic [7:0]    r_rsp_data;
  logic          w_push, w_pop, w_rsp_free, w_head_bad;
  logic [1:0]    w_head_slave;
  logic [7:0]    w_head_data;

  assign req_ready        = r_count < CW'(DEPTH);
  assign w_push           = req_valid && req_ready;
  // A response being consumed on this edge frees the slot for the next pop.
  assign w_rsp_free       = !r_rsp_valid || rsp_ready;
  assign w_head_slave     = r_mem_slave[r_rd_ptr];
  assign w_head_data      = r_mem_data[r_rd_ptr];
  assign w_head_bad       = w_head_slave == 2'd3;
  assign slaveSelect      = r_slave;
  assign masterDataToSend = r_data;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_err          = r_rsp_err;
  assign rsp_slave        = r_rsp_slave;
  assign rsp_data         = r_rsp_data;
  assign busy             = r_state != S_IDLE || r_count != '0;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_slave[r_wr_ptr] <= req_slave;
      r_mem_data[r_wr_ptr]  <= req_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic; GAP=0 skips the gap state entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_next = w_head_bad ? (GAP == 0 ? S_IDLE : S_GAP) : S_START;
      S_START:   w_next = S_SHIFT;
      S_SHIFT:   if (r_cnt == 4'd7) w_next = S_CAPTURE;
      S_CAPTURE: w_next = GAP == 0 ? S_IDLE : S_GAP;
      S_GAP:     if (r_cnt == 4'(GAP - 1)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM outputs: launch pulse and FIFO pop.
  always_comb begin
    start = r_state == S_START;
    w_pop = r_state == S_IDLE && r_count != '0 && w_rsp_free;
  end

  // Shared shift/gap counter, cleared on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= w_next != r_state ? 4'd0 : r_cnt + 4'd1;
  end

  // Holding registers (legal commands only) and the response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slave     <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_slave <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_pop && !w_head_bad) begin
        r_slave <= w_head_slave;
        r_data  <= w_head_data;
      end
      if (w_pop && w_head_bad) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_slave <= 2'd3;
        r_rsp_data  <= 8'h00;
      end else if (r_state == S_CAPTURE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_slave <= r_slave;
        r_rsp_data  <= masterDataReceived;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb_spi_cmd_scheduler: scoreboard bench; instance 0 (GAP=1) is fully checked, instances 1/2 (GAP=0/3) check streaming spacing
module tb_spi_cmd_scheduler;
  logic       clk = 0, reset = 0;
  logic       req_valid [3], req_ready [3], start [3], rsp_valid [3], rsp_ready [3], rsp_err [3], busy [3];
  logic [1:0] req_slave [3], slaveSelect [3], rsp_slave [3];
  logic [7:0] req_data [3], masterDataToSend [3], masterDataReceived [3], rsp_data [3];

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GP = g == 0 ? 1 : g == 1 ? 0 : 3;
    assign masterDataReceived[g] = masterDataToSend[g] ^ 8'h99;
    spi_cmd_scheduler #(.DEPTH(4), .GAP(GP)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_slave(req_slave[g]), .req_data(req_data[g]), .start(start[g]),
      .slaveSelect(slaveSelect[g]), .masterDataToSend(masterDataToSend[g]),
      .masterDataReceived(masterDataReceived[g]), .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]), .rsp_slave(rsp_slave[g]),
      .rsp_err(rsp_err[g]), .busy(busy[g]));
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [10:0] exp_q [$];
  logic [9:0]  ln_q [$];
  logic [9:0]  cur_ln = '0;
  int          n_st [3];
  int          t_last [3];
  int          gaps [3][16];
  int          t_rv = 0;
  logic        prev_rv = 0;

  // Monitor: launches, response timing and scoreboard compare on handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (start[i]) begin
      n_st[i]++;
      gaps[i][n_st[i] % 16] = cyc - t_last[i];
      t_last[i] = cyc;
    end
    if (start[0]) begin
      if (ln_q.size() == 0) check("start_unexpected", 1, 0);
      else begin
        cur_ln = ln_q.pop_front();
        check("launch", {slaveSelect[0], masterDataToSend[0]}, cur_ln);
      end
    end
    if (rsp_valid[0] && !prev_rv) begin
      t_rv = cyc;
      if (!rsp_err[0]) check("hold_to_capture", {slaveSelect[0], masterDataToSend[0]}, cur_ln);
    end
    prev_rv = rsp_valid[0];
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp", {rsp_err[0], rsp_slave[0], rsp_data[0]}, exp_q.pop_front());
    end
  end

  task automatic push(input int i, input logic [1:0] s, input logic [7:0] d, output int e);
    req_slave[i] = s; req_data[i] = d; req_valid[i] = 1; e = -1;
    for (int k = 0; k < 300 && e < 0; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin @(posedge clk); #1; e = cyc; end
    end
    req_valid[i] = 0;
    if (e < 0) check("push_timeout", 0, 1);
    else if (i == 0) begin
      exp_q.push_back(s == 2'd3 ? {1'b1, 2'd3, 8'h00} : {1'b0, s, d ^ 8'h99});
      if (s != 2'd3) ln_q.push_back({s, d});
    end
  endtask

  task automatic drain();
    int k = 0;
    while (k < 600 && (exp_q.size() != 0 || busy[0])) begin @(posedge clk); #1; k++; end
    if (k == 600) check("drain_timeout", 0, 1);
  endtask

  task automatic stream(input int i, input int exp_gap);
    int base = n_st[i], e, k = 0;
    push(i, 2'd0, 8'h10, e); push(i, 2'd1, 8'h20, e); push(i, 2'd2, 8'h30, e);
    while (k < 300 && n_st[i] < base + 3) begin @(posedge clk); #1; k++; end
    if (k == 300) check("stream_timeout", 0, 1);
    check("stream_gap_a", gaps[i][(base + 2) % 16], exp_gap);
    check("stream_gap_b", gaps[i][(base + 3) % 16], exp_gap);
    if (i == 0) drain();
    else repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, s0, c, k;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_slave[i] = 0; req_data[i] = 0; rsp_ready[i] = 1;
      n_st[i] = 0; t_last[i] = 0;
      for (int j = 0; j < 16; j++) gaps[i][j] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready[0], 1);
    check("rst_start", start[0], 0);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_outputs", {slaveSelect[0], masterDataToSend[0], rsp_data[0], rsp_slave[0], rsp_err[0]}, 0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    s0 = n_st[0];
    push(0, 2'd1, 8'hA5, e);
    drain();
    check("single_starts", n_st[0] - s0, 1);
    check("lat_start", t_last[0] - e, 1);
    check("lat_rsp", t_rv - e, 11);

    s0 = n_st[0];
    push(0, 2'd3, 8'hFF, e);
    drain();
    check("illegal_no_start", n_st[0] - s0, 0);

    rsp_ready[0] = 0;
    push(0, 2'd0, 8'h11, e); push(0, 2'd1, 8'h22, e); push(0, 2'd2, 8'h33, e);
    push(0, 2'd0, 8'h44, e); push(0, 2'd1, 8'h55, e);
    check("fill_ready_low", req_ready[0], 0);
    check("fill_busy", busy[0], 1);
    rsp_ready[0] = 1;
    push(0, 2'd2, 8'h66, e);
    drain();

    rsp_ready[0] = 0;
    push(0, 2'd1, 8'h5A, e); push(0, 2'd2, 8'hC3, e);
    k = 0;
    while (k < 100 && !rsp_valid[0]) begin @(posedge clk); #1; k++; end
    if (k == 100) check("bp_rsp_timeout", 0, 1);
    s0 = n_st[0];
    repeat (20) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid[0], rsp_err[0], rsp_slave[0], rsp_data[0]}, {1'b1, exp_q[0]});
      check("bp_no_start", n_st[0], s0);
    end
    @(posedge clk); #1;
    c = cyc;
    rsp_ready[0] = 1;
    drain();
    check("bp_second_start", n_st[0] - s0, 1);
    check("bp_start_after_hs", t_last[0] - c, 1);

    s0 = n_st[0];
    push(0, 2'd2, 8'h77, e);
    while (cyc < e + 6) begin @(posedge clk); #1; end
    reset = 0;
    #1;
    check("rst_mid_start", start[0], 0);
    check("rst_mid_rsp_valid", rsp_valid[0], 0);
    check("rst_mid_req_ready", req_ready[0], 1);
    check("rst_mid_busy", busy[0], 0);
    exp_q.delete(); ln_q.delete();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    s0 = n_st[0];
    push(0, 2'd0, 8'h3E, e);
    drain();
    check("post_rst_starts", n_st[0] - s0, 1);
    check("post_rst_lat", t_rv - e, 11);

    stream(0, 12);
    stream(1, 11);
    stream(2, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, command FIFO depth (power of 2, 2..16).
REQ-002 The block SHALL have one parameter: GAP, default 1, idle cycles between transfers (0..15).
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  command offered.
REQ-006 req_ready  output  1  command FIFO can accept.
REQ-007 req_slave  input  2  target slave; 0..2 valid, 3 illegal.
REQ-008 req_data  input  8  byte to transmit.
REQ-009 start  output  1  one-cycle transfer launch to the SPI master.
REQ-010 slaveSelect  output  2  slave index to the master.
REQ-011 masterDataToSend  output  8  byte to the master.
REQ-012 masterDataReceived  input  8  byte shifted in by the master.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_data  output  8  received byte (0 on error).
REQ-016 rsp_slave  output  2  slave index of the response.
REQ-017 rsp_err  output  1  command had illegal slave index.
REQ-018 busy  output  1  FSM not IDLE, or FIFO non-empty.

Function
REQ-019 Command FIFO: push on req_valid && req_ready; req_ready = (count < DEPTH); pop only by FSM in IDLE; simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states: IDLE, START, SHIFT, CAPTURE, GAP_WAIT.
REQ-021 IDLE: if FIFO non-empty and rsp_valid == 0, pop head into holding registers; slave 0..2 -> START; slave 3 -> set rsp_valid=1, rsp_err=1, rsp_data=0, rsp_slave=3, go GAP_WAIT; no start pulse.
REQ-022 START: start=1 for exactly this one cycle; -> SHIFT with 4-bit counter cleared.
REQ-023 SHIFT: exactly 8 cycles (counter 0..7), start=0; -> CAPTURE.
REQ-024 CAPTURE: one cycle; at its closing edge latch rsp_data <= masterDataReceived, rsp_slave, rsp_err=0, rsp_valid=1; -> GAP_WAIT.
REQ-025 GAP_WAIT: GAP cycles (GAP=0 -> straight to IDLE next edge); -> IDLE.
REQ-026 slaveSelect and masterDataToSend SHALL be driven from holding registers, stable from START through CAPTURE, unchanged otherwise.
REQ-027 rsp_valid SHALL hold, with rsp_* stable, until the edge where rsp_ready=1, then clear; no new pop while rsp_valid=1.
REQ-028 Latency: command accepted at edge E into empty idle block with rsp_ready=1 -> start high in cycle after E+1, rsp_valid rises at edge E+11.
REQ-029 Back-to-back, GAP=1, rsp_ready tied 1: successive start pulses 12 cycles apart.
REQ-030 req_ready SHALL be independent of FSM state; FIFO may fill during a transfer.

Reset
REQ-031 reset low SHALL immediately force IDLE, empty FIFO, start=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_slave=0, slaveSelect=0, masterDataToSend=0, busy=0, req_ready=1.
REQ-032 Reset mid-transfer SHALL abort without response; after release, first command behaves as from power-up.

Verification
REQ-033 Single: push slave 1, data 0xA5, master model returns 0x3C -> one start pulse, slaveSelect=1, masterDataToSend=0xA5 throughout, rsp_valid at E+11 with rsp_data=0x3C, rsp_slave=1, rsp_err=0.
REQ-034 Fill: push 5 commands with DEPTH=4 while idle-stalled by rsp_ready=0 -> req_ready low after 4 queued/held as per count, no command lost or duplicated, responses in order.
REQ-035 Illegal: push slave 3, data 0xFF -> no start pulse, rsp_valid with rsp_err=1, rsp_data=0x00, rsp_slave=3.
REQ-036 Backpressure: rsp_ready=0 for 20 cycles with two queued -> rsp_* stable, second start only after rsp_ready handshake.
REQ-037 Reset in SHIFT (counter=4) -> start=0, rsp_valid=0, FIFO empty, req_ready=1 immediately; next push completes normally.
REQ-038 Streaming, GAP=0 and GAP=3, rsp_ready=1 -> start pulses exactly 11 and 14 cycles apart.
